anim_sequencer: RTL and testbench

//  Parametrised frame sequencer for screen animations. Replaces the fixed 16-step, fixed-divider stepper.

---
 rtl/anim_pkg.sv | 22 ++
 rtl/anim_sequencer_if.sv | 16 +
 rtl/anim_prescaler.sv | 37 +++
 rtl/anim_sequencer.sv | 129 ++++++++++++
 tb/tb_anim_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/anim_pkg.sv
// Shared definitions for the animation sequencer: playback modes, direction
// encoding and the frame-index width helper.
package anim_pkg;

  typedef enum logic [1:0] {
    ANIM_LOOP     = 2'b00,
    ANIM_PINGPONG = 2'b01,
    ANIM_ONESHOT  = 2'b10,
    ANIM_HOLD     = 2'b11
  } anim_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } anim_dir_e;

  // Frame index width; a single-frame animation still needs one bit.
  function automatic int unsigned frame_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/anim_sequencer_if.sv
// Frame ROM read port: the sequencer drives frame/x/y, the ROM returns data
// combinationally.
interface anim_sequencer_if #(
  parameter int unsigned FRAME_W = 4,
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 8,
  parameter int unsigned DATA_W  = 16
);
  logic [FRAME_W-1:0] frame;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [DATA_W-1:0]  data;

  modport master (output frame, output x, output y, input data);
  modport slave  (input frame, input x, input y, output data);
endinterface

// File: rtl/anim_prescaler.sv
// Frame-period prescaler: counts clk cycles and fires adv_o once per
// effective period (a period of 0 behaves as 1).
module anim_prescaler #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             adv_o
);

  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0] last_cnt;

  // >= rather than == so a period shrunk below the current count fires at once.
  always_comb begin
    last_cnt   = (period_i == '0) ? '0 : period_i - DIV_W'(1);
    adv_o      = en_i && !clr_i && (tick_cnt_q >= last_cnt);
    tick_cnt_d = tick_cnt_q;
    if (clr_i) begin
      tick_cnt_d = '0;
    end else if (en_i) begin
      tick_cnt_d = adv_o ? '0 : tick_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/anim_sequencer.sv
// Animation frame sequencer: steps the frame index per playback mode, addresses
// the frame ROM and registers the returned pixel.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = 16,
  parameter int unsigned FRAME_W    = frame_w(NUM_FRAMES),
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 8,
  parameter int unsigned DATA_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_i,
  input  logic               play_i,
  input  logic               restart_i,
  input  logic [DIV_W-1:0]   period_i,
  input  logic [X_W-1:0]     ram_addr_x_i,
  input  logic [Y_W-1:0]     ram_addr_y_i,
  anim_sequencer_if.master   rom,
  output logic [DATA_W-1:0]  pix_data_o,
  output logic [FRAME_W-1:0] frame_idx_o,
  output logic               frame_tick_o,
  output logic               done_o
);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_W-1:0] PREV_LAST  =
    (NUM_FRAMES > 1) ? FRAME_W'(NUM_FRAMES - 2) : '0;

  anim_mode_e         mode_e;
  anim_dir_e          dir_q;
  logic [FRAME_W-1:0] frame_idx_q, frame_inc, frame_dec;
  logic               frame_tick_q, done_q, adv;
  logic [DATA_W-1:0]  pix_data_q;

  assign mode_e    = anim_mode_e'(mode_i);
  assign frame_inc = frame_idx_q + FRAME_W'(1);
  assign frame_dec = frame_idx_q - FRAME_W'(1);

  // HOLD parks the prescaler at zero while playing; pause freezes it as-is.
  anim_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (restart_i || (play_i && (mode_e == ANIM_HOLD))),
    .en_i     (play_i && (mode_e != ANIM_HOLD)),
    .period_i (period_i),
    .adv_o    (adv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_idx_q  <= '0;
      dir_q        <= DIR_UP;
      done_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      if (restart_i) begin
        frame_idx_q <= '0;
        dir_q       <= DIR_UP;
        done_q      <= 1'b0;
      end else if (adv) begin
        unique case (mode_e)
          ANIM_LOOP: begin
            dir_q        <= DIR_UP;
            frame_tick_q <= 1'b1;
            frame_idx_q  <= (frame_idx_q >= LAST_FRAME) ? '0 : frame_inc;
          end
          ANIM_PINGPONG: begin
            frame_tick_q <= 1'b1;
            if (NUM_FRAMES == 1) begin
              frame_idx_q <= '0;
            end else if (dir_q == DIR_UP) begin
              // Turn around at the end even if we arrived here from another mode.
              if (frame_idx_q >= LAST_FRAME) begin
                frame_idx_q <= PREV_LAST;
                dir_q       <= DIR_DOWN;
              end else begin
                frame_idx_q <= frame_inc;
                if (frame_inc == LAST_FRAME) dir_q <= DIR_DOWN;
              end
            end else begin
              if (frame_idx_q == '0) begin
                frame_idx_q <= FRAME_W'(1);
                dir_q       <= DIR_UP;
              end else begin
                frame_idx_q <= frame_dec;
                if (frame_dec == '0) dir_q <= DIR_UP;
              end
            end
          end
          ANIM_ONESHOT: begin
            if (!done_q) begin
              if (frame_idx_q >= LAST_FRAME) begin
                done_q <= 1'b1;
              end else begin
                frame_idx_q  <= frame_inc;
                frame_tick_q <= 1'b1;
                if (frame_inc == LAST_FRAME) done_q <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Pixel pipeline register runs regardless of play state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data_q <= '0;
    end else begin
      pix_data_q <= rom.data;
    end
  end

  assign rom.frame    = frame_idx_q;
  assign rom.x        = ram_addr_x_i;
  assign rom.y        = ram_addr_y_i;
  assign pix_data_o   = pix_data_q;
  assign frame_idx_o  = frame_idx_q;
  assign frame_tick_o = frame_tick_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed self-checking bench for anim_sequencer with 16-, 5- and 4-frame instances.
module tb_anim_sequencer;

  logic        clk;
  logic        rst, play, restart;
  logic [1:0]  mode;
  logic [23:0] period;
  logic [7:0]  ax, ay;

  logic [3:0]  f16;  logic [2:0] f5;  logic [1:0] f4;
  logic        tk16, tk5, tk4, dn16, dn5, dn4;
  logic [15:0] px16, px5, px4;

  int n_checks = 0;
  int n_errors = 0;

  anim_sequencer_if #(.FRAME_W(4)) if16 ();
  anim_sequencer_if #(.FRAME_W(3)) if5 ();
  anim_sequencer_if #(.FRAME_W(2)) if4 ();

  function automatic logic [15:0] rom_fn(input logic [3:0] f, input logic [7:0] x,
                                         input logic [7:0] y);
    return {f, 12'h000} ^ {x, y};
  endfunction

  assign if16.data = rom_fn(4'(if16.frame), if16.x, if16.y);
  assign if5.data  = rom_fn(4'(if5.frame), if5.x, if5.y);
  assign if4.data  = rom_fn(4'(if4.frame), if4.x, if4.y);

  anim_sequencer #(.NUM_FRAMES(16)) u16 (
    .clk(clk), .rst(rst), .mode_i(mode), .play_i(play), .restart_i(restart),
    .period_i(period), .ram_addr_x_i(ax), .ram_addr_y_i(ay), .rom(if16.master),
    .pix_data_o(px16), .frame_idx_o(f16), .frame_tick_o(tk16), .done_o(dn16));

  anim_sequencer #(.NUM_FRAMES(5)) u5 (
    .clk(clk), .rst(rst), .mode_i(mode), .play_i(play), .restart_i(restart),
    .period_i(period), .ram_addr_x_i(ax), .ram_addr_y_i(ay), .rom(if5.master),
    .pix_data_o(px5), .frame_idx_o(f5), .frame_tick_o(tk5), .done_o(dn5));

  anim_sequencer #(.NUM_FRAMES(4)) u4 (
    .clk(clk), .rst(rst), .mode_i(mode), .play_i(play), .restart_i(restart),
    .period_i(period), .ram_addr_x_i(ax), .ram_addr_y_i(ay), .rom(if4.master),
    .pix_data_o(px4), .frame_idx_o(f4), .frame_tick_o(tk4), .done_o(dn4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;      // 0: 16 frames, 1: 5 frames, 2: 4 frames
    logic        rst;
    logic        restart;
    logic        play;
    logic [1:0]  mode;
    logic [23:0] period;
    int          ef;
    logic        et;
    logic        ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int sel, input logic r, input logic rs, input logic p,
                     input logic [1:0] m, input logic [23:0] per, input int ef,
                     input logic et, input logic ed);
    vec_t v;
    v.sel = sel; v.rst = r; v.restart = rs; v.play = p; v.mode = m;
    v.period = per; v.ef = ef; v.et = et; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic rs, input logic p,
                       input logic [1:0] m, input logic [23:0] per);
    rst = r; restart = rs; play = p; mode = m; period = per;
  endtask

  int ef_prev, ef_now;
  logic [15:0] exp_pix;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 2'b00, 24'd3);
    ax = 8'h00; ay = 8'h00;

    // Reset values on every instance
    cyc();
    chk("rst_frame16", int'(f16), 0); chk("rst_tick16", int'(tk16), 0);
    chk("rst_done16", int'(dn16), 0); chk("rst_pix16", int'(px16), 0);
    chk("rst_frame5", int'(f5), 0);   chk("rst_frame4", int'(f4), 0);

    // LOOP, period 3, 16 frames, with pixel path tracking
    drive(1'b0, 1'b0, 1'b1, 2'b00, 24'd3);
    ef_prev = 0;
    for (int c = 1; c <= 51; c++) begin
      ax = 8'(c * 7); ay = 8'(c * 3);
      exp_pix = rom_fn(4'(ef_prev), ax, ay);
      cyc();
      ef_now = (c / 3) % 16;
      chk($sformatf("loop_frame_c%0d", c), int'(f16), ef_now);
      chk($sformatf("loop_tick_c%0d", c), int'(tk16), (c % 3 == 0) ? 1 : 0);
      chk($sformatf("loop_pix_c%0d", c), int'(px16), int'(exp_pix));
      ef_prev = ef_now;
    end

    // Table: PINGPONG on 5 frames, then ONESHOT on 4 frames
    add(1, 1, 0, 0, 2'b01, 24'd1, 0, 0, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 1, 1, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 2, 1, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 3, 1, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 4, 1, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 3, 1, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 2, 1, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 1, 1, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 0, 1, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 1, 1, 0);
    add(1, 0, 0, 0, 2'b01, 24'd1, 1, 0, 0);
    add(1, 0, 0, 0, 2'b01, 24'd1, 1, 0, 0);
    add(1, 0, 1, 0, 2'b01, 24'd1, 0, 0, 0);
    add(1, 0, 0, 1, 2'b01, 24'd1, 1, 1, 0);
    add(2, 1, 0, 0, 2'b10, 24'd2, 0, 0, 0);
    add(2, 0, 0, 1, 2'b10, 24'd2, 0, 0, 0);
    add(2, 0, 0, 1, 2'b10, 24'd2, 1, 1, 0);
    add(2, 0, 0, 1, 2'b10, 24'd2, 1, 0, 0);
    add(2, 0, 0, 1, 2'b10, 24'd2, 2, 1, 0);
    add(2, 0, 0, 1, 2'b10, 24'd2, 2, 0, 0);
    add(2, 0, 0, 1, 2'b10, 24'd2, 3, 1, 1);
    add(2, 0, 0, 1, 2'b10, 24'd2, 3, 0, 1);
    add(2, 0, 0, 1, 2'b10, 24'd2, 3, 0, 1);
    add(2, 0, 0, 1, 2'b10, 24'd2, 3, 0, 1);
    add(2, 0, 0, 1, 2'b10, 24'd2, 3, 0, 1);
    add(2, 0, 1, 1, 2'b10, 24'd2, 0, 0, 0);
    add(2, 0, 0, 1, 2'b10, 24'd2, 0, 0, 0);
    add(2, 0, 0, 1, 2'b10, 24'd2, 1, 1, 0);

    foreach (vecs[i]) begin
      int af, at, ad;
      drive(vecs[i].rst, vecs[i].restart, vecs[i].play, vecs[i].mode, vecs[i].period);
      cyc();
      case (vecs[i].sel)
        1:       begin af = int'(f5); at = int'(tk5); ad = int'(dn5); end
        2:       begin af = int'(f4); at = int'(tk4); ad = int'(dn4); end
        default: begin af = int'(f16); at = int'(tk16); ad = int'(dn16); end
      endcase
      chk($sformatf("vec%0d_frame", i), af, vecs[i].ef);
      chk($sformatf("vec%0d_tick", i), at, int'(vecs[i].et));
      chk($sformatf("vec%0d_done", i), ad, int'(vecs[i].ed));
    end

    // Pause mid-frame in LOOP period 4, resume, then restart while paused
    drive(1'b1, 1'b0, 1'b0, 2'b00, 24'd4); cyc();
    drive(1'b0, 1'b0, 1'b1, 2'b00, 24'd4);
    for (int c = 1; c <= 6; c++) cyc();
    chk("pause_pre_frame", int'(f16), 1);
    play = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk($sformatf("pause_frame_%0d", c), int'(f16), 1);
      chk($sformatf("pause_tick_%0d", c), int'(tk16), 0);
    end
    play = 1'b1; cyc();
    chk("resume1_frame", int'(f16), 1); chk("resume1_tick", int'(tk16), 0);
    cyc();
    chk("resume2_frame", int'(f16), 2); chk("resume2_tick", int'(tk16), 1);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 24'd4); cyc();
    chk("pause_restart_frame", int'(f16), 0); chk("pause_restart_tick", int'(tk16), 0);
    restart = 1'b0; cyc();
    chk("pause_after_restart", int'(f16), 0);

    // period 0 advances every clock
    drive(1'b1, 1'b0, 1'b0, 2'b00, 24'd0); cyc();
    drive(1'b0, 1'b0, 1'b1, 2'b00, 24'd0);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      chk($sformatf("p0_frame_c%0d", c), int'(f16), c);
      chk($sformatf("p0_tick_c%0d", c), int'(tk16), 1);
    end

    // Period shrink 100 -> 2 with tick_cnt at 50
    drive(1'b1, 1'b0, 1'b0, 2'b00, 24'd100); cyc();
    drive(1'b0, 1'b0, 1'b1, 2'b00, 24'd100);
    for (int c = 1; c <= 50; c++) cyc();
    chk("shrink_pre_frame", int'(f16), 0);
    period = 24'd2; cyc();
    chk("shrink_adv_frame", int'(f16), 1); chk("shrink_adv_tick", int'(tk16), 1);
    cyc();
    chk("shrink_mid_frame", int'(f16), 1); chk("shrink_mid_tick", int'(tk16), 0);
    cyc();
    chk("shrink_next_frame", int'(f16), 2); chk("shrink_next_tick", int'(tk16), 1);

    // HOLD freezes the frame
    mode = 2'b11;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk($sformatf("hold_frame_%0d", c), int'(f16), 2);
      chk($sformatf("hold_tick_%0d", c), int'(tk16), 0);
    end

    // Reset mid-frame while PINGPONG is heading down on 5 frames
    drive(1'b1, 1'b0, 1'b0, 2'b01, 24'd2); cyc();
    drive(1'b0, 1'b0, 1'b1, 2'b01, 24'd2);
    for (int c = 1; c <= 11; c++) cyc();
    chk("pp_down_frame", int'(f5), 3); chk("pp_down_tick", int'(tk5), 0);
    ax = 8'h5a; ay = 8'hc3;
    rst = 1'b1; cyc();
    chk("pp_rst_frame", int'(f5), 0); chk("pp_rst_tick", int'(tk5), 0);
    chk("pp_rst_done", int'(dn5), 0); chk("pp_rst_pix", int'(px5), 0);
    drive(1'b0, 1'b0, 1'b1, 2'b01, 24'd1); cyc();
    chk("pp_after_frame", int'(f5), 1); chk("pp_after_tick", int'(tk5), 1);
    chk("pp_after_pix", int'(px5), int'(rom_fn(4'd0, 8'h5a, 8'hc3)));
    cyc();
    chk("pp_after2_frame", int'(f5), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
